// File: rtl/zbt_pattern_checker.sv
// Read-back checker for the ZBT test pattern: scans both banks over both frame
// locations and compares every word against the expected checkerboard.
`ifndef LOG_MEM
`define LOG_MEM 36
`endif
`ifndef LOG_ADDR
`define LOG_ADDR 20
`endif

module zbt_pattern_checker #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ERR_W        = 16,
    parameter int unsigned H_PIXELS     = 640,
    parameter int unsigned V_LINES      = 480
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [`LOG_MEM-1:0]  mem0_read,
    input  logic [`LOG_MEM-1:0]  mem1_read,
    output logic [`LOG_ADDR-1:0] mem0_addr,
    output logic [`LOG_ADDR-1:0] mem1_addr,
    output logic                 mem0_wr,
    output logic                 mem1_wr,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [`LOG_ADDR-1:0] first_err_addr,
    output logic                 first_err_bank,
    output logic                 first_err_frame
);

    localparam int unsigned AW          = `LOG_ADDR;
    localparam int unsigned MW          = `LOG_MEM;
    localparam int unsigned EW1         = ERR_W + 1;
    localparam int unsigned FRAME_WORDS = H_PIXELS * V_LINES;
    localparam logic [9:0]  X_LAST      = 10'(H_PIXELS - 1);
    localparam logic [8:0]  Y_LAST      = 9'(V_LINES - 1);
    localparam logic [2:0]  CNT_LAST    = 3'(READ_LATENCY - 1);

    localparam logic [MW-1:0] MEM0_LIGHT = MW'(36'b111111111100011000111111111100011000);
    localparam logic [MW-1:0] MEM1_LIGHT = MW'(36'b111111111000010000111111111000010000);
    localparam logic [MW-1:0] DARK_WORD  = MW'(36'b000000001000010000000000001000010000);

    typedef enum logic [1:0] {IDLE, SCAN0, SCAN1, DRAIN} state_t;

    typedef struct packed {
        logic          vld;
        logic          loc;
        logic [AW-1:0] addr;
        logic [MW-1:0] exp0;
        logic [MW-1:0] exp1;
    } tag_t;

    function automatic logic [AW-1:0] word_addr(input logic loc, input logic [9:0] x,
                                                 input logic [8:0] y);
        return AW'((loc ? FRAME_WORDS : 32'd0) + 32'(y) * H_PIXELS + 32'(x));
    endfunction

    state_t          state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [8:0]      y_q, y_d;
    logic            loc_q, loc_d;
    logic            issue_q, issue_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic            fe_seen_q, fe_seen_d;
    logic [AW-1:0]   fe_addr_q, fe_addr_d;
    logic            fe_bank_q, fe_bank_d;
    logic            fe_frame_q, fe_frame_d;
    tag_t            pipe_q [READ_LATENCY];
    tag_t            issue_tag;
    tag_t            tail;
    logic            light;
    logic            last_word;
    logic            bad0, bad1;
    logic [EW1-1:0]  sum;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        loc_d     = loc_q;
        issue_d   = 1'b0;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        last_word = (x_q == X_LAST) && (y_q == Y_LAST);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN0;
                    x_d     = '0;
                    y_d     = '0;
                    loc_d   = 1'b0;
                    issue_d = 1'b1;
                end
            end
            SCAN0, SCAN1: begin
                issue_d = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + 9'd1;
                end else begin
                    x_d = x_q + 10'd1;
                end
                // Frame 1 follows frame 0 with no bubble; only SCAN1 ends issuing.
                if (last_word) begin
                    x_d = '0;
                    y_d = '0;
                    if (state_q == SCAN0) begin
                        state_d = SCAN1;
                        loc_d   = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        issue_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue_d) begin
            addr_d = word_addr(loc_d, x_d, y_d);
        end
    end

    always_comb begin
        light          = loc_q ? (x_q[5] ^ y_q[5]) : (x_q[4] ^ y_q[4]);
        issue_tag.vld  = issue_q;
        issue_tag.loc  = loc_q;
        issue_tag.addr = addr_q;
        issue_tag.exp0 = light ? MEM0_LIGHT : DARK_WORD;
        issue_tag.exp1 = light ? MEM1_LIGHT : DARK_WORD;
    end

    assign tail = pipe_q[READ_LATENCY-1];

    always_comb begin
        bad0       = tail.vld && (mem0_read != tail.exp0);
        bad1       = tail.vld && (mem1_read != tail.exp1);
        sum        = {1'b0, err_q} + EW1'(bad0) + EW1'(bad1);
        err_d      = err_q;
        pass_d     = pass_q;
        fe_seen_d  = fe_seen_q;
        fe_addr_d  = fe_addr_q;
        fe_bank_d  = fe_bank_q;
        fe_frame_d = fe_frame_q;
        if (state_q == IDLE && start) begin
            err_d      = '0;
            pass_d     = 1'b0;
            fe_seen_d  = 1'b0;
            fe_addr_d  = '0;
            fe_bank_d  = 1'b0;
            fe_frame_d = 1'b0;
        end else begin
            err_d = sum[ERR_W] ? '1 : sum[ERR_W-1:0];
            if ((bad0 || bad1) && !fe_seen_q) begin
                fe_seen_d  = 1'b1;
                fe_addr_d  = tail.addr;
                fe_bank_d  = !bad0;
                fe_frame_d = tail.loc;
            end
            // The final compare lands on the same edge that raises done.
            if (done_d) begin
                pass_d = (err_d == '0);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            loc_q      <= 1'b0;
            issue_q    <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fe_seen_q  <= 1'b0;
            fe_addr_q  <= '0;
            fe_bank_q  <= 1'b0;
            fe_frame_q <= 1'b0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            loc_q      <= loc_d;
            issue_q    <= issue_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fe_seen_q  <= fe_seen_d;
            fe_addr_q  <= fe_addr_d;
            fe_bank_q  <= fe_bank_d;
            fe_frame_q <= fe_frame_d;
            pipe_q[0]  <= issue_tag;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign mem0_addr       = addr_q;
    assign mem1_addr       = addr_q;
    assign mem0_wr         = 1'b0;
    assign mem1_wr         = 1'b0;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_addr  = fe_addr_q;
    assign first_err_bank  = fe_bank_q;
    assign first_err_frame = fe_frame_q;

endmodule

// File: tb/tb_zbt_pattern_checker.sv
// Bench for zbt_pattern_checker on a reduced 64x40 frame: scoreboarded scan
// results for three read latencies plus reset/restart/back-to-back sequences.
module tb_zbt_pattern_checker;

    localparam int H  = 64;
    localparam int V  = 40;
    localparam int FW = H * V;
    localparam int W  = 2 * FW;
    localparam logic [35:0] L0 = 36'b111111111100011000111111111100011000;
    localparam logic [35:0] L1 = 36'b111111111000010000111111111000010000;
    localparam logic [35:0] DK = 36'b000000001000010000000000001000010000;

    typedef struct {
        int inst; int cyc; int pass; int err; int faddr; int fbank; int fframe;
    } exp_t;

    typedef struct {
        int kind; int pass; int err; int faddr; int fbank; int fframe;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset  = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic start4 = 1'b0;

    logic [35:0] mem0_m [W];
    logic [35:0] mem1_m [W];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int dones  = 0;
    int pushed = 0;
    int wr_bad = 0;
    exp_t sbq[$];

    // instance a: latency 2, 12-bit counter
    logic [19:0] a_addr0, a_addr1, a_faddr;
    logic        a_wr0, a_wr1, a_busy, a_done, a_pass, a_fbank, a_fframe;
    logic [11:0] a_err;
    logic [35:0] a_rd0, a_rd1;
    logic [1:0][35:0] pa0, pa1;
    // instance b: latency 1
    logic [19:0] b_addr0, b_addr1, b_faddr;
    logic        b_wr0, b_wr1, b_busy, b_done, b_pass, b_fbank, b_fframe;
    logic [15:0] b_err;
    logic [35:0] b_rd0, b_rd1;
    logic [35:0] pb0, pb1;
    // instance c: latency 4
    logic [19:0] c_addr0, c_addr1, c_faddr;
    logic        c_wr0, c_wr1, c_busy, c_done, c_pass, c_fbank, c_fframe;
    logic [15:0] c_err;
    logic [35:0] c_rd0, c_rd1;
    logic [3:0][35:0] pc0, pc1;

    zbt_pattern_checker #(.READ_LATENCY(2), .ERR_W(12), .H_PIXELS(H), .V_LINES(V)) u_a (
        .clock(clk), .reset(reset), .start(start0),
        .mem0_read(a_rd0), .mem1_read(a_rd1),
        .mem0_addr(a_addr0), .mem1_addr(a_addr1), .mem0_wr(a_wr0), .mem1_wr(a_wr1),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .first_err_addr(a_faddr), .first_err_bank(a_fbank), .first_err_frame(a_fframe));

    zbt_pattern_checker #(.READ_LATENCY(1), .ERR_W(16), .H_PIXELS(H), .V_LINES(V)) u_b (
        .clock(clk), .reset(reset), .start(start1),
        .mem0_read(b_rd0), .mem1_read(b_rd1),
        .mem0_addr(b_addr0), .mem1_addr(b_addr1), .mem0_wr(b_wr0), .mem1_wr(b_wr1),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_err_addr(b_faddr), .first_err_bank(b_fbank), .first_err_frame(b_fframe));

    zbt_pattern_checker #(.READ_LATENCY(4), .ERR_W(16), .H_PIXELS(H), .V_LINES(V)) u_c (
        .clock(clk), .reset(reset), .start(start4),
        .mem0_read(c_rd0), .mem1_read(c_rd1),
        .mem0_addr(c_addr0), .mem1_addr(c_addr1), .mem0_wr(c_wr0), .mem1_wr(c_wr1),
        .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
        .first_err_addr(c_faddr), .first_err_bank(c_fbank), .first_err_frame(c_fframe));

    function automatic logic [35:0] mem_rd(input logic [19:0] a, input bit bank);
        if (int'(a) >= W) return '0;
        return bank ? mem1_m[a] : mem0_m[a];
    endfunction

    // Behavioural ZBT: data for an address shows up LAT cycles later.
    always @(posedge clk) begin
        pa0 <= {pa0[0], mem_rd(a_addr0, 1'b0)};
        pa1 <= {pa1[0], mem_rd(a_addr1, 1'b1)};
        pb0 <= mem_rd(b_addr0, 1'b0);
        pb1 <= mem_rd(b_addr1, 1'b1);
        pc0 <= {pc0[2:0], mem_rd(c_addr0, 1'b0)};
        pc1 <= {pc1[2:0], mem_rd(c_addr1, 1'b1)};
    end
    assign a_rd0 = pa0[1];
    assign a_rd1 = pa1[1];
    assign b_rd0 = pb0;
    assign b_rd1 = pb1;
    assign c_rd0 = pc0[3];
    assign c_rd1 = pc1[3];

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 2 : (inst == 1) ? 1 : 4;
    endfunction

    function automatic logic [35:0] pat(input int bank, input int loc, input int x, input int y);
        int light;
        light = loc != 0 ? (((x >> 5) ^ (y >> 5)) & 1) : (((x >> 4) ^ (y >> 4)) & 1);
        if (light == 0) return DK;
        return (bank != 0) ? L1 : L0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_clean();
        for (int loc = 0; loc < 2; loc++)
            for (int y = 0; y < V; y++)
                for (int x = 0; x < H; x++) begin
                    mem0_m[loc * FW + y * H + x] = pat(0, loc, x, y);
                    mem1_m[loc * FW + y * H + x] = pat(1, loc, x, y);
                end
    endtask

    task automatic apply_fault(input int kind);
        case (kind)
            1: mem1_m[FW + 0 * H + 32] ^= 36'h1;
            2: begin
                mem0_m[7 * H + 5] ^= 36'h4;
                mem1_m[7 * H + 5] ^= 36'h4;
                mem1_m[7 * H + 6] ^= 36'h100;
            end
            3: for (int i = 0; i < W; i++) begin
                mem0_m[i] = '0;
                mem1_m[i] = '0;
            end
            default: ;
        endcase
    endtask

    task automatic on_done(input int inst, input int p, input int e, input int fa,
                           input int fb, input int ff);
        exp_t x;
        dones++;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done inst=%0d: got done=1 expected done=0", inst);
        end else begin
            x = sbq.pop_front();
            chk("done_inst", inst, x.inst);
            chk("done_cycle", cyc, x.cyc);
            chk("pass", p, x.pass);
            chk("err_count", e, x.err);
            chk("first_err_addr", fa, x.faddr);
            chk("first_err_bank", fb, x.fbank);
            chk("first_err_frame", ff, x.fframe);
        end
    endtask

    always @(negedge clk) begin
        if (a_wr0 | a_wr1 | b_wr0 | b_wr1 | c_wr0 | c_wr1) wr_bad++;
        if (a_done) on_done(0, int'(a_pass), int'(a_err), int'(a_faddr), int'(a_fbank), int'(a_fframe));
        if (b_done) on_done(1, int'(b_pass), int'(b_err), int'(b_faddr), int'(b_fbank), int'(b_fframe));
        if (c_done) on_done(2, int'(c_pass), int'(c_err), int'(c_faddr), int'(c_fbank), int'(c_fframe));
    end

    task automatic push_exp(input int inst, input int n, input vec_t v);
        exp_t x;
        x.inst = inst; x.cyc = n + W + lat_of(inst);
        x.pass = v.pass; x.err = v.err; x.faddr = v.faddr; x.fbank = v.fbank; x.fframe = v.fframe;
        sbq.push_back(x);
        pushed++;
    endtask

    task automatic start_scan(input int inst, input vec_t v, output int n);
        @(negedge clk);
        case (inst)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start4 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        n = cyc;
        push_exp(inst, n, v);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int i;
        d0 = dones;
        i = 0;
        while (dones == d0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (dones == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles expected one", budget);
            sbq.delete();
        end
    endtask

    vec_t tbl[4];
    vec_t v_clean;

    initial begin
        int n;
        int i;
        tbl[0] = '{kind: 0, pass: 1, err: 0,    faddr: 0,          fbank: 0, fframe: 0};
        tbl[1] = '{kind: 1, pass: 0, err: 1,    faddr: FW + 32,    fbank: 1, fframe: 1};
        tbl[2] = '{kind: 2, pass: 0, err: 3,    faddr: 7 * H + 5,  fbank: 0, fframe: 0};
        tbl[3] = '{kind: 3, pass: 0, err: 4095, faddr: 0,          fbank: 0, fframe: 0};
        v_clean = tbl[0];

        fill_clean();
        repeat (3) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_err", a_err, 0);
        chk("rst_addr", a_addr0, 0);
        chk("rst_faddr", a_faddr, 0);
        chk("rst_fbank", a_fbank, 0);
        chk("rst_fframe", a_fframe, 0);
        reset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            fill_clean();
            apply_fault(tbl[t].kind);
            start_scan(0, tbl[t], n);
            chk("busy_after_start", a_busy, 1);
            wait_done(W + 40);
        end

        // start pulsed mid-SCAN0 must not disturb the scan
        fill_clean();
        start_scan(0, v_clean, n);
        repeat (100) @(negedge clk);
        chk("midscan_busy", a_busy, 1);
        chk("addr_k", a_addr0, cyc - n);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        while (cyc < n + FW + 70) @(negedge clk);
        chk("addr0_frame1", a_addr0, FW + 70);
        chk("addr1_frame1", a_addr1, FW + 70);
        wait_done(W + 40);

        // start held during the done cycle is taken on the next edge
        start_scan(0, v_clean, n);
        i = 0;
        while (!a_done && i < W + 40) begin
            @(negedge clk);
            i++;
        end
        chk("b2b_done_seen", a_done, 1);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        chk("b2b_accept_busy", a_busy, 1);
        push_exp(0, cyc, v_clean);
        wait_done(W + 40);

        // reset at k=1000; a fault at k=999 is still in flight in the pipeline
        fill_clean();
        apply_fault(2);
        mem0_m[999] ^= 36'h1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        n = cyc;
        while (cyc < n + 1000) @(negedge clk);
        chk("err_before_reset", a_err, 3);
        chk("faddr_before_reset", a_faddr, 7 * H + 5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_err", a_err, 0);
        chk("mid_rst_faddr", a_faddr, 0);
        chk("mid_rst_addr", a_addr0, 0);
        chk("mid_rst_done", a_done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("err_after_reset", a_err, 0);
        chk("busy_after_reset", a_busy, 0);
        repeat (W + 10) @(negedge clk);

        fill_clean();
        start_scan(0, v_clean, n);
        wait_done(W + 40);

        start_scan(1, v_clean, n);
        wait_done(W + 40);
        start_scan(2, v_clean, n);
        wait_done(W + 40);

        repeat (5) @(negedge clk);
        chk("mem_wr_never", wr_bad, 0);
        chk("done_count", dones, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
